// File: rtl/pipelined_carry_select_adder.sv
// Two-stage pipelined carry-select adder/subtractor with a valid/ready handshake.
// Stage 1 precomputes per-block sums for carry-in 0 and 1; stage 2 ripples the block selects.
module pipelined_carry_select_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int unsigned NBLK = WIDTH / BLOCK;
    localparam int unsigned MSB  = WIDTH - 1;

    generate
        if ((WIDTH % BLOCK) != 0 || WIDTH < BLOCK) begin : g_param_check
            $error("pipelined_carry_select_adder: WIDTH must be a non-zero multiple of BLOCK");
        end
    endgenerate

    // Stage 1 state
    logic                        st1_valid_q, st1_valid_d;
    logic [NBLK-1:0][BLOCK-1:0]  blk_sum0_q, blk_sum0_d;
    logic [NBLK-1:0][BLOCK-1:0]  blk_sum1_q, blk_sum1_d;
    logic [NBLK-1:0]             blk_cy0_q, blk_cy0_d;
    logic [NBLK-1:0]             blk_cy1_q, blk_cy1_d;
    logic                        cin_q, cin_d;
    logic                        a_msb_q, a_msb_d;
    logic                        bx_msb_q, bx_msb_d;

    // Output stage state
    logic                        out_valid_q, out_valid_d;
    logic [WIDTH-1:0]            sum_q, sum_d;
    logic                        cout_q, cout_d;
    logic                        ovf_q, ovf_d;

    logic                        out_load;
    logic                        st1_adv;
    logic                        accept;
    logic [WIDTH-1:0]            bx;
    logic [WIDTH-1:0]            sel_sum;
    logic                        ripple_c;

    assign out_load = !out_valid_q || out_ready;
    assign st1_adv  = !st1_valid_q || out_load;
    assign accept   = in_valid && st1_adv;
    assign in_ready = st1_adv;

    // Stage 1: invert B for subtract and precompute both carry-in cases per block
    always_comb begin
        bx          = sub ? ~B : B;
        st1_valid_d = st1_valid_q;
        blk_sum0_d  = blk_sum0_q;
        blk_sum1_d  = blk_sum1_q;
        blk_cy0_d   = blk_cy0_q;
        blk_cy1_d   = blk_cy1_q;
        cin_d       = cin_q;
        a_msb_d     = a_msb_q;
        bx_msb_d    = bx_msb_q;
        if (st1_adv) begin
            st1_valid_d = in_valid;
        end
        if (accept) begin
            cin_d    = sub | Cin;
            a_msb_d  = A[MSB];
            bx_msb_d = bx[MSB];
            for (int k = 0; k < int'(NBLK); k++) begin
                {blk_cy0_d[k], blk_sum0_d[k]} = {1'b0, A[k*BLOCK +: BLOCK]}
                                              + {1'b0, bx[k*BLOCK +: BLOCK]};
                {blk_cy1_d[k], blk_sum1_d[k]} = {1'b0, A[k*BLOCK +: BLOCK]}
                                              + {1'b0, bx[k*BLOCK +: BLOCK]}
                                              + (BLOCK+1)'(1);
            end
        end
    end

    // Stage 2: carry ripples only through the block select muxes
    always_comb begin
        sel_sum  = '0;
        ripple_c = cin_q;
        for (int k = 0; k < int'(NBLK); k++) begin
            sel_sum[k*BLOCK +: BLOCK] = ripple_c ? blk_sum1_q[k] : blk_sum0_q[k];
            ripple_c                  = ripple_c ? blk_cy1_q[k]  : blk_cy0_q[k];
        end
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        if (out_load) begin
            out_valid_d = st1_valid_q;
            if (st1_valid_q) begin
                sum_d  = sel_sum;
                cout_d = ripple_c;
                ovf_d  = (a_msb_q == bx_msb_q) && (sel_sum[MSB] != a_msb_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st1_valid_q <= 1'b0;
            blk_sum0_q  <= '0;
            blk_sum1_q  <= '0;
            blk_cy0_q   <= '0;
            blk_cy1_q   <= '0;
            cin_q       <= 1'b0;
            a_msb_q     <= 1'b0;
            bx_msb_q    <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            st1_valid_q <= st1_valid_d;
            blk_sum0_q  <= blk_sum0_d;
            blk_sum1_q  <= blk_sum1_d;
            blk_cy0_q   <= blk_cy0_d;
            blk_cy1_q   <= blk_cy1_d;
            cin_q       <= cin_d;
            a_msb_q     <= a_msb_d;
            bx_msb_q    <= bx_msb_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Bench for pipelined_carry_select_adder (WIDTH=8, BLOCK=4): directed vectors with literal
// expectations plus an arithmetic reference model checked on every output transfer.
module tb_pipelined_carry_select_adder;

    localparam int unsigned W  = 8;
    localparam int unsigned BW = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Ovf;

    int errors = 0;
    int checks = 0;
    int pops   = 0;

    logic [W+1:0] exp_q[$];
    logic [W+1:0] exp_v;
    logic [W+1:0] prev_out;
    logic         prev_stall;
    logic         rnd_done;

    pipelined_carry_select_adder #(.WIDTH(W), .BLOCK(BW)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Sum      (Sum),
        .Cout     (Cout),
        .Ovf      (Ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic; returns {ovf, cout, sum}
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input logic s);
        longint m, ua, ub, ci, full, sa, sb, sr;
        m    = longint'(1) << W;
        ua   = longint'(a);
        ub   = s ? (m - 1 - longint'(b)) : longint'(b);
        ci   = s ? 1 : longint'(c);
        full = ua + ub + ci;
        sa   = (ua >= m / 2) ? ua - m : ua;
        sb   = (ub >= m / 2) ? ub - m : ub;
        sr   = sa + sb + ci;
        return {(sr >= m / 2) || (sr < -(m / 2)), full >= m, W'(full % m)};
    endfunction

    // Scoreboard: push on accept, compare on transfer, enforce hold under backpressure
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", longint'(out_valid), 1);
                chk("hold_data", longint'({Ovf, Cout, Sum}), longint'(prev_out));
            end
            if (out_valid && exp_q.size() == 0) begin
                chk("spurious_out_valid", longint'(out_valid), 0);
            end else if (out_valid && out_ready) begin
                exp_v = exp_q.pop_front();
                pops++;
                chk("model_result", longint'({Ovf, Cout, Sum}), longint'(exp_v));
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {Ovf, Cout, Sum};
            if (in_valid && in_ready) exp_q.push_back(model(A, B, Cin, sub));
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
        bit acc;
        int guard;
        A        = a;
        B        = b;
        Cin      = c;
        sub      = s;
        in_valid = 1'b1;
        acc      = 1'b0;
        guard    = 0;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic op_chk(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        int n;
        send(a, b, c, s);
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_latency"}, n, 2);
        chk({name, "_sum"}, longint'(Sum), longint'(es));
        chk({name, "_cout"}, longint'(Cout), longint'(ec));
        chk({name, "_ovf"}, longint'(Ovf), longint'(eo));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int p0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        Cin       = 1'b0;
        sub       = 1'b0;
        rnd_done  = 1'b0;
        prev_stall = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_sum", longint'(Sum), 0);
        chk("reset_cout", longint'(Cout), 0);
        chk("reset_ovf", longint'(Ovf), 0);
        rst_n = 1'b1;
        #1;
        chk("post_reset_in_ready", longint'(in_ready), 1);

        // Directed vectors (hand-computed)
        op_chk("add_ff_01",     8'hff, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op_chk("add_ff_ff_c1",  8'hff, 8'hff, 1'b1, 1'b0, 8'hff, 1'b1, 1'b0);
        op_chk("add_f0_b0_c1",  8'hf0, 8'hb0, 1'b1, 1'b0, 8'ha1, 1'b1, 1'b0);
        op_chk("add_7f_01",     8'h7f, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        op_chk("sub_05_03",     8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
        op_chk("sub_03_05_c1",  8'h03, 8'h05, 1'b1, 1'b1, 8'hfe, 1'b0, 1'b0);
        op_chk("sub_80_01",     8'h80, 8'h01, 1'b0, 1'b1, 8'h7f, 1'b1, 1'b1);
        op_chk("sub_00_00",     8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        op_chk("add_0f_01",     8'h0f, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        op_chk("add_0f_00_c1",  8'h0f, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);

        // Inputs wiggling without in_valid must produce nothing
        for (int i = 0; i < 4; i++) begin
            A   = W'($urandom);
            B   = W'($urandom);
            sub = 1'($urandom);
            @(posedge clk);
            #1;
        end
        chk("idle_no_output", longint'(out_valid), 0);

        // Backpressure: 5 ops, out_ready low for 3 cycles
        p0        = pops;
        out_ready = 1'b0;
        fork
            begin
                send(8'h11, 8'h22, 1'b0, 1'b0);
                send(8'h90, 8'h90, 1'b0, 1'b0);
                send(8'h40, 8'h41, 1'b0, 1'b1);
                send(8'hfe, 8'h01, 1'b1, 1'b0);
                send(8'h33, 8'h33, 1'b1, 1'b1);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("bp_full_in_ready", longint'(in_ready), 0);
                chk("bp_out_valid", longint'(out_valid), 1);
                chk("bp_head_sum", longint'(Sum), 8'h33);
                out_ready = 1'b1;
            end
        join
        drain("bp");
        chk("bp_delivered", pops - p0, 5);

        // Reset while a result is live
        send(8'hff, 8'hff, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_mid_pre_valid", longint'(out_valid), 1);
        chk("rst_mid_pre_sum", longint'(Sum), 8'hfe);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", longint'(out_valid), 0);
        chk("rst_mid_sum", longint'(Sum), 0);
        chk("rst_mid_cout", longint'(Cout), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_mid_in_ready", longint'(in_ready), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_no_output", longint'(out_valid), 0);

        // Random back-to-back ops with random out_ready
        p0 = pops;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain("rand");
        chk("rand_delivered", pops - p0, 300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
